// File: rtl/mesh_pkg.sv
// Shared constants, types and helpers for the mesh traffic generator.
package mesh_pkg;

    // NIC CPU-side register map
    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Status registers report presence/full on this bit
    localparam int STAT_BIT = 0;

    // Packet field offsets
    localparam int F_VC       = 63;
    localparam int F_DIR_X    = 62;
    localparam int F_DIR_Y    = 61;
    localparam int F_HOP_X    = 52;
    localparam int F_HOP_Y    = 48;
    localparam int F_SRC_ID   = 40;
    localparam int F_DST_ID   = 32;
    localparam int F_MARK     = 24;
    localparam int F_PAY_SRC  = 16;
    localparam int F_SEQ      = 0;

    localparam logic [7:0] MARKER = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_STAT,
        S_RX_STAT_W,
        S_RX_READ,
        S_RX_READ_W,
        S_TX_STAT,
        S_TX_STAT_W,
        S_TX_WRITE,
        S_GAP,
        S_LOOP
    } state_e;

    typedef enum logic [1:0] {
        MODE_FIXED     = 2'd0,
        MODE_RANDOM    = 2'd1,
        MODE_SWEEP     = 2'd2,
        MODE_TRANSPOSE = 2'd3
    } mode_e;

    // Linear node id: row-major over the mesh
    function automatic logic [7:0] node_id(input logic [3:0] x, input logic [3:0] y,
                                           input int size_y);
        return 8'(int'(x) * size_y + int'(y));
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mesh_dest_sel.sv
// Destination selection: mode mux, LFSR, sweep index, skip and hop/direction.
module mesh_dest_sel
    import mesh_pkg::*;
#(
    parameter int          SIZE_X    = 4,
    parameter int          SIZE_Y    = 4,
    parameter int          MY_X      = 0,
    parameter int          MY_Y      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  mode_e      mode,
    input  logic [7:0] fixed_dest,
    input  logic       advance,
    output logic       skip,
    output logic [7:0] dest_id,
    output logic       dir_x,
    output logic       dir_y,
    output logic [3:0] hop_x,
    output logic [3:0] hop_y
);

    localparam logic [3:0] MY_X4  = 4'(MY_X);
    localparam logic [3:0] MY_Y4  = 4'(MY_Y);
    localparam logic [3:0] LAST_X = 4'(SIZE_X - 1);
    localparam logic [3:0] LAST_Y = 4'(SIZE_Y - 1);

    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  sx_q, sx_d, sy_q, sy_d;
    logic [3:0]  dest_x, dest_y;
    logic [4:0]  diff_x, diff_y;
    logic        lfsr_fb;

    // LFSR and sweep position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
            sx_q   <= '0;
            sy_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
        end
    end

    // Step the generator that belongs to the active mode
    always_comb begin
        lfsr_d  = lfsr_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        if (advance && mode == MODE_RANDOM) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
        if (advance && mode == MODE_SWEEP) begin
            if (sy_q == LAST_Y) begin
                sy_d = '0;
                sx_d = (sx_q == LAST_X) ? 4'd0 : sx_q + 4'd1;
            end else begin
                sy_d = sy_q + 4'd1;
            end
        end
    end

    // Destination mux, skip detection and signed hop computation
    always_comb begin
        dest_x = '0;
        dest_y = '0;
        unique case (mode)
            MODE_FIXED:  {dest_x, dest_y} = fixed_dest;
            MODE_RANDOM: begin
                dest_x = 4'(int'(lfsr_q[7:4]) % SIZE_X);
                dest_y = 4'(int'(lfsr_q[3:0]) % SIZE_Y);
            end
            MODE_SWEEP: begin
                dest_x = sx_q;
                dest_y = sy_q;
            end
            default: begin
                dest_x = MY_Y4;
                dest_y = MY_X4;
            end
        endcase
        skip    = (dest_x == MY_X4 && dest_y == MY_Y4) || (dest_x > LAST_X) || (dest_y > LAST_Y);
        diff_x  = {1'b0, dest_x} - {1'b0, MY_X4};
        diff_y  = {1'b0, dest_y} - {1'b0, MY_Y4};
        dir_x   = diff_x[4];
        dir_y   = diff_y[4];
        hop_x   = diff_x[4] ? 4'(5'd0 - diff_x) : diff_x[3:0];
        hop_y   = diff_y[4] ? 4'(5'd0 - diff_y) : diff_y[3:0];
        dest_id = node_id(dest_x, dest_y, SIZE_Y);
    end

endmodule

// File: rtl/mesh_traffic_gen.sv
// Per-node traffic generator and checker driving a NIC's CPU register port.
module mesh_traffic_gen
    import mesh_pkg::*;
#(
    parameter int          PACKET_WIDTH = 64,
    parameter int          SIZE_X       = 4,
    parameter int          SIZE_Y       = 4,
    parameter int          MY_X         = 0,
    parameter int          MY_Y         = 0,
    parameter int          NUM_PACKETS  = 16,
    parameter int          INJ_GAP      = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [7:0]              fixed_dest,
    output logic [1:0]              nic_addr,
    output logic [PACKET_WIDTH-1:0] nic_d_in,
    input  logic [PACKET_WIDTH-1:0] nic_d_out,
    output logic                    nic_en,
    output logic                    nic_en_wr,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic [15:0]             err_count,
    output logic                    done
);

    localparam logic [7:0]  SRC_ID    = node_id(4'(MY_X), 4'(MY_Y), SIZE_Y);
    localparam bit          HAS_LIMIT = (NUM_PACKETS > 0);
    localparam logic [15:0] LIMIT16   = 16'(NUM_PACKETS);
    localparam logic [7:0]  GAP_LAST  = 8'((INJ_GAP > 0) ? INJ_GAP - 1 : 0);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] rx_count_q, rx_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] seq_q, seq_d;
    logic [7:0]  gap_q, gap_d;
    logic        done_q, done_d;

    logic        advance;
    logic        skip;
    logic [7:0]  dest_id;
    logic        dir_x, dir_y;
    logic [3:0]  hop_x, hop_y;
    logic [PACKET_WIDTH-1:0] pkt;
    logic        unused_rd_bits;

    // Only presence bit, destination id and marker of read data matter
    assign unused_rd_bits = ^{nic_d_out[PACKET_WIDTH-1:40], nic_d_out[23:1]};

    mesh_dest_sel #(
        .SIZE_X    (SIZE_X),
        .SIZE_Y    (SIZE_Y),
        .MY_X      (MY_X),
        .MY_Y      (MY_Y),
        .LFSR_SEED (LFSR_SEED)
    ) u_dest_sel (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode_q),
        .fixed_dest (fixed_dest),
        .advance    (advance),
        .skip       (skip),
        .dest_id    (dest_id),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .hop_x      (hop_x),
        .hop_y      (hop_y)
    );

    // State and counter registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_FIXED;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            seq_q       <= '0;
            gap_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            seq_q       <= seq_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
        end
    end

    // Outgoing packet image for the current destination and sequence number
    always_comb begin
        pkt                       = '0;
        pkt[F_VC]                 = seq_q[0];
        pkt[F_DIR_X]              = dir_x;
        pkt[F_DIR_Y]              = dir_y;
        pkt[F_HOP_X +: 4]         = hop_x;
        pkt[F_HOP_Y +: 4]         = hop_y;
        pkt[F_SRC_ID +: 8]        = SRC_ID;
        pkt[F_DST_ID +: 8]        = dest_id;
        pkt[F_MARK +: 8]          = MARKER;
        pkt[F_PAY_SRC +: 8]       = SRC_ID;
        pkt[F_SEQ +: 16]          = seq_q;
    end

    // Poll receive first, then transmit; strobes last exactly one cycle
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        tx_count_d  = tx_count_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        seq_d       = seq_q;
        gap_d       = gap_q;
        advance     = 1'b0;
        nic_en      = 1'b0;
        nic_en_wr   = 1'b0;
        nic_addr    = '0;
        nic_d_in    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d  = mode_e'(mode);
                    state_d = S_RX_STAT;
                end
            end
            S_RX_STAT: begin
                nic_en   = 1'b1;
                nic_addr = NIC_IN_STAT;
                state_d  = S_RX_STAT_W;
            end
            S_RX_STAT_W: begin
                state_d = nic_d_out[STAT_BIT] ? S_RX_READ : S_TX_STAT;
            end
            S_RX_READ: begin
                nic_en   = 1'b1;
                nic_addr = NIC_IN_DATA;
                state_d  = S_RX_READ_W;
            end
            S_RX_READ_W: begin
                rx_count_d = sat_inc(rx_count_q);
                if (nic_d_out[F_MARK +: 8] != MARKER || nic_d_out[F_DST_ID +: 8] != SRC_ID) begin
                    err_count_d = sat_inc(err_count_q);
                end
                state_d = S_TX_STAT;
            end
            S_TX_STAT: begin
                if (done_q || skip) begin
                    // Self destinations in stepping modes move on to the next candidate
                    advance = !done_q;
                    state_d = S_LOOP;
                end else begin
                    nic_en   = 1'b1;
                    nic_addr = NIC_OUT_STAT;
                    state_d  = S_TX_STAT_W;
                end
            end
            S_TX_STAT_W: begin
                state_d = nic_d_out[STAT_BIT] ? S_LOOP : S_TX_WRITE;
            end
            S_TX_WRITE: begin
                nic_en     = 1'b1;
                nic_en_wr  = 1'b1;
                nic_addr   = NIC_OUT_DATA;
                nic_d_in   = pkt;
                tx_count_d = sat_inc(tx_count_q);
                seq_d      = seq_q + 16'd1;
                advance    = 1'b1;
                gap_d      = '0;
                state_d    = (INJ_GAP == 0) ? S_LOOP : S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_LOOP;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_LOOP: begin
                state_d = enable ? S_RX_STAT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = done_q | (HAS_LIMIT && tx_count_d == LIMIT16);
    end

    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mesh_traffic_gen.sv
// Self-checking bench: two generators (node (0,0) limited, node (1,1) unlimited)
// each in front of a behavioural NIC register model.
module tb_mesh_traffic_gen;
    import mesh_pkg::*;

    localparam int PW = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A: node (0,0), 16 packets, gap 4 ----------------
    logic          a_enable = 1'b0, a_en, a_wr, a_done, a_full = 1'b0;
    logic [1:0]    a_mode = 2'd0, a_addr;
    logic [7:0]    a_fdest = 8'h00;
    logic [PW-1:0] a_din, a_dout = '0;
    logic [15:0]   a_tx, a_rx, a_err;

    // ---------------- DUT B: node (1,1), unlimited, gap 1 ----------------
    logic          b_enable = 1'b0, b_en, b_wr, b_done, b_full = 1'b0;
    logic [1:0]    b_mode = 2'd0, b_addr;
    logic [7:0]    b_fdest = 8'h00;
    logic [PW-1:0] b_din, b_dout = '0;
    logic [15:0]   b_tx, b_rx, b_err;

    mesh_traffic_gen #(.PACKET_WIDTH(PW), .SIZE_X(4), .SIZE_Y(4), .MY_X(0), .MY_Y(0),
                       .NUM_PACKETS(16), .INJ_GAP(4), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .mode(a_mode), .fixed_dest(a_fdest),
        .nic_addr(a_addr), .nic_d_in(a_din), .nic_d_out(a_dout), .nic_en(a_en),
        .nic_en_wr(a_wr), .tx_count(a_tx), .rx_count(a_rx), .err_count(a_err), .done(a_done));

    mesh_traffic_gen #(.PACKET_WIDTH(PW), .SIZE_X(4), .SIZE_Y(4), .MY_X(1), .MY_Y(1),
                       .NUM_PACKETS(0), .INJ_GAP(1), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .mode(b_mode), .fixed_dest(b_fdest),
        .nic_addr(b_addr), .nic_d_in(b_din), .nic_d_out(b_dout), .nic_en(b_en),
        .nic_en_wr(b_wr), .tx_count(b_tx), .rx_count(b_rx), .err_count(b_err), .done(b_done));

    // ---------------- NIC models and scoreboard state ----------------
    logic [PW-1:0] rxq_a[$], rxq_b[$];
    logic [PW-1:0] txlog_a[$], txlog_b[$];
    logic [PW-1:0] exp_q[$];
    int a_polls = 0, b_polls = 0, a_writes = 0, b_writes = 0, proto_errs = 0;
    int checks = 0, errors = 0;

    // NIC A: read data appears for the cycle after the strobe
    always @(negedge clk) begin
        if (a_en && !a_wr) begin
            case (a_addr)
                NIC_IN_STAT:  a_dout = {{(PW-1){1'b0}}, rxq_a.size() > 0};
                NIC_IN_DATA:  a_dout = (rxq_a.size() > 0) ? rxq_a.pop_front() : '0;
                NIC_OUT_STAT: begin a_dout = {{(PW-1){1'b0}}, a_full}; a_polls++; end
                default:      a_dout = '0;
            endcase
        end
        if (a_en && a_wr) begin
            a_writes++;
            if (a_addr == NIC_OUT_DATA) txlog_a.push_back(a_din); else proto_errs++;
        end
        if (!a_en && (a_addr != 2'b00 || a_din != '0 || a_wr)) proto_errs++;
    end

    // NIC B: same register behaviour
    always @(negedge clk) begin
        if (b_en && !b_wr) begin
            case (b_addr)
                NIC_IN_STAT:  b_dout = {{(PW-1){1'b0}}, rxq_b.size() > 0};
                NIC_IN_DATA:  b_dout = (rxq_b.size() > 0) ? rxq_b.pop_front() : '0;
                NIC_OUT_STAT: begin b_dout = {{(PW-1){1'b0}}, b_full}; b_polls++; end
                default:      b_dout = '0;
            endcase
        end
        if (b_en && b_wr) begin
            b_writes++;
            if (b_addr == NIC_OUT_DATA) txlog_b.push_back(b_din); else proto_errs++;
        end
        if (!b_en && (b_addr != 2'b00 || b_din != '0 || b_wr)) proto_errs++;
    end

    // Reference packet built straight from the field definitions
    function automatic logic [PW-1:0] exp_pkt(int sx, int sy, int dx, int dy, int seq);
        logic [PW-1:0] p;
        int ddx, ddy, src, dst;
        ddx = dx - sx;
        ddy = dy - sy;
        src = sx * 4 + sy;
        dst = dx * 4 + dy;
        p = '0;
        p[63]    = (seq % 2) == 1;
        p[62]    = ddx < 0;
        p[61]    = ddy < 0;
        p[55:52] = 4'((ddx < 0) ? -ddx : ddx);
        p[51:48] = 4'((ddy < 0) ? -ddy : ddy);
        p[47:40] = 8'(src);
        p[39:32] = 8'(dst);
        p[31:0]  = {8'hA5, 8'(src), 16'(seq)};
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_enable = 1'b0; b_enable = 1'b0; a_full = 1'b0; b_full = 1'b0;
        repeat (3) @(negedge clk);
        rxq_a.delete(); rxq_b.delete(); txlog_a.delete(); txlog_b.delete(); exp_q.delete();
        a_polls = 0; b_polls = 0; a_writes = 0; b_writes = 0;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_en, a_wr, a_addr} !== 4'b0 || a_din !== '0) begin
            errors++; $display("FAIL reset_nic_a got en=%b wr=%b addr=%b din=%h want 0", a_en, a_wr, a_addr, a_din);
        end
        checks++;
        if ({a_tx, a_rx, a_err, a_done} !== 49'd0) begin
            errors++; $display("FAIL reset_cnt_a got tx=%0d rx=%0d err=%0d done=%b want 0", a_tx, a_rx, a_err, a_done);
        end
        checks++;
        if ({b_en, b_wr, b_addr, b_tx, b_rx, b_err, b_done} !== 53'd0 || b_din !== '0) begin
            errors++; $display("FAIL reset_b got en=%b tx=%0d rx=%0d err=%0d done=%b want 0", b_en, b_tx, b_rx, b_err, b_done);
        end
        checks++;
        if (dut_a.state_q !== S_IDLE || dut_b.state_q !== S_IDLE) begin
            errors++; $display("FAIL reset_state got a=%0d b=%0d want %0d", dut_a.state_q, dut_b.state_q, S_IDLE);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_a.state_q !== S_IDLE || a_en !== 1'b0) begin
            errors++; $display("FAIL idle_hold got state=%0d en=%b want %0d 0", dut_a.state_q, a_en, S_IDLE);
        end
    endtask

    task automatic test_fixed_done();
        int cyc;
        logic [PW-1:0] pkt;
        do_reset();
        a_mode = 2'd0; a_fdest = 8'h23; a_enable = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_pkt(0, 0, 2, 3, i));
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++;
        if (a_done !== 1'b1 || a_tx !== 16'd16) begin
            errors++; $display("FAIL fixed_done got done=%b tx=%0d want 1 16", a_done, a_tx);
        end
        checks++;
        if (txlog_a.size() != 16) begin
            errors++; $display("FAIL fixed_count got %0d writes want 16", txlog_a.size());
        end
        for (int i = 0; i < 16 && i < txlog_a.size(); i++) begin
            pkt = exp_q.pop_front();
            checks++;
            if (txlog_a[i] !== pkt) begin
                errors++; $display("FAIL fixed_pkt[%0d] got %h want %h", i, txlog_a[i], pkt);
            end
        end
        // After done: no further writes, still draining receive
        pkt = {$urandom, $urandom};
        pkt[39:32] = 8'h00; pkt[31:24] = 8'hA5;
        rxq_a.push_back(pkt);
        repeat (150) @(negedge clk);
        checks++;
        if (txlog_a.size() != 16 || a_done !== 1'b1 || a_tx !== 16'd16) begin
            errors++; $display("FAIL post_done got writes=%0d done=%b tx=%0d want 16 1 16", txlog_a.size(), a_done, a_tx);
        end
        checks++;
        if (a_rx !== 16'd1 || a_err !== 16'd0) begin
            errors++; $display("FAIL post_done_rx got rx=%0d err=%0d want 1 0", a_rx, a_err);
        end
    endtask

    task automatic test_full();
        int cyc;
        logic [PW-1:0] want;
        do_reset();
        a_full = 1'b1; a_mode = 2'd0; a_fdest = 8'h23; a_enable = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (a_writes != 0 || a_tx !== 16'd0) begin
            errors++; $display("FAIL full_nowrite got writes=%0d tx=%0d want 0 0", a_writes, a_tx);
        end
        checks++;
        if (a_polls < 10) begin
            errors++; $display("FAIL full_polling got %0d status polls want >= 10", a_polls);
        end
        a_full = 1'b0;
        cyc = 0;
        while (txlog_a.size() < 1 && cyc < 200) begin @(negedge clk); cyc++; end
        want = exp_pkt(0, 0, 2, 3, 0);
        checks++;
        if (txlog_a.size() < 1 || txlog_a[0] !== want) begin
            errors++; $display("FAIL full_release got n=%0d want first pkt %h", txlog_a.size(), want);
        end
    endtask

    task automatic test_rx_check();
        int cyc;
        logic [PW-1:0] pkt;
        do_reset();
        a_mode = 2'd0; a_fdest = 8'h00; a_enable = 1'b1;
        pkt = {$urandom, $urandom};
        pkt[39:32] = 8'h00; pkt[31:24] = 8'hA5;
        rxq_a.push_back(pkt);
        cyc = 0;
        while (a_rx !== 16'd1 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (a_rx !== 16'd1 || a_err !== 16'd0) begin
            errors++; $display("FAIL rx_good got rx=%0d err=%0d want 1 0", a_rx, a_err);
        end
        pkt[31:24] = 8'h00;
        rxq_a.push_back(pkt);
        cyc = 0;
        while (a_rx !== 16'd2 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (a_rx !== 16'd2 || a_err !== 16'd1) begin
            errors++; $display("FAIL rx_bad got rx=%0d err=%0d want 2 1", a_rx, a_err);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (a_writes != 0 || a_done !== 1'b0) begin
            errors++; $display("FAIL self_fixed got writes=%0d done=%b want 0 0", a_writes, a_done);
        end
    endtask

    task automatic test_rx_random();
        int cyc, kind, exp_err;
        logic [PW-1:0] pkt;
        logic [7:0] r;
        do_reset();
        b_mode = 2'd0; b_fdest = 8'h11; b_enable = 1'b1;
        exp_err = 0;
        for (int i = 0; i < 30; i++) begin
            pkt = {$urandom, $urandom};
            kind = $urandom_range(0, 2);
            r = 8'($urandom_range(1, 255));
            pkt[39:32] = (kind == 2) ? 8'd5 ^ r : 8'd5;
            pkt[31:24] = (kind == 1) ? 8'hA5 ^ r : 8'hA5;
            if (kind != 0) exp_err++;
            rxq_b.push_back(pkt);
        end
        cyc = 0;
        while (b_rx !== 16'd30 && cyc < 2000) begin @(negedge clk); cyc++; end
        checks++;
        if (b_rx !== 16'd30 || b_err !== 16'(exp_err)) begin
            errors++; $display("FAIL rx_random got rx=%0d err=%0d want 30 %0d", b_rx, b_err, exp_err);
        end
    endtask

    task automatic test_sweep();
        int cyc, id;
        logic [PW-1:0] pkt;
        do_reset();
        b_mode = 2'd2; b_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b_mode = 2'd0; b_fdest = 8'h00;   // mode is latched; this must be ignored
        id = 0;
        while (exp_q.size() < 20) begin
            if (id != 5) exp_q.push_back(exp_pkt(1, 1, id / 4, id % 4, exp_q.size()));
            id = (id + 1) % 16;
        end
        cyc = 0;
        while (txlog_b.size() < 20 && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++;
        if (txlog_b.size() < 20) begin
            errors++; $display("FAIL sweep_timeout got %0d writes want 20", txlog_b.size());
        end
        for (int i = 0; i < 20 && i < txlog_b.size(); i++) begin
            pkt = exp_q.pop_front();
            checks++;
            if (txlog_b[i] !== pkt) begin
                errors++; $display("FAIL sweep_pkt[%0d] got dst=%0d %h want dst=%0d %h", i, txlog_b[i][39:32], txlog_b[i], pkt[39:32], pkt);
            end
        end
        checks++;
        if (b_done !== 1'b0) begin
            errors++; $display("FAIL unlimited_done got %b want 0", b_done);
        end
    endtask

    task automatic test_random();
        int cyc, dx, dy, bad;
        logic [15:0] l;
        logic fb;
        logic [PW-1:0] pkt;
        do_reset();
        b_mode = 2'd1; b_enable = 1'b1;
        l = 16'hACE1;
        while (exp_q.size() < 100) begin
            dx = int'(l[7:4]) % 4;
            dy = int'(l[3:0]) % 4;
            fb = l[0] ^ l[2] ^ l[3] ^ l[5];
            l = {fb, l[15:1]};
            if (dx == 1 && dy == 1) continue;
            exp_q.push_back(exp_pkt(1, 1, dx, dy, exp_q.size()));
        end
        cyc = 0;
        while (txlog_b.size() < 100 && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++;
        if (txlog_b.size() < 100) begin
            errors++; $display("FAIL random_timeout got %0d writes want 100", txlog_b.size());
        end
        bad = 0;
        for (int i = 0; i < 100 && i < txlog_b.size(); i++) begin
            pkt = exp_q.pop_front();
            if (txlog_b[i] !== pkt || txlog_b[i][39:32] == 8'd5) begin
                if (bad < 5) $display("FAIL random_pkt[%0d] got %h want %h", i, txlog_b[i], pkt);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL random_seq got %0d bad packets want 0", bad);
        end
    endtask

    task automatic test_skip();
        do_reset();
        a_mode = 2'd0; a_fdest = 8'h50; a_enable = 1'b1;   // row 5 is outside a 4x4 mesh
        b_mode = 2'd3; b_enable = 1'b1;                    // transpose of (1,1) is self
        repeat (200) @(negedge clk);
        checks++;
        if (a_writes != 0 || a_done !== 1'b0 || a_tx !== 16'd0) begin
            errors++; $display("FAIL skip_range got writes=%0d done=%b want 0 0", a_writes, a_done);
        end
        checks++;
        if (b_writes != 0 || b_tx !== 16'd0) begin
            errors++; $display("FAIL skip_transpose got writes=%0d want 0", b_writes);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [PW-1:0] first;
        do_reset();
        a_mode = 2'd0; a_fdest = 8'h23; a_enable = 1'b1;
        cyc = 0;
        while (!(txlog_a.size() >= 1 && dut_a.state_q == S_TX_STAT_W) && cyc < 500) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (dut_a.state_q != S_TX_STAT_W) begin
            errors++; $display("FAIL mid_reach got state=%0d want %0d", dut_a.state_q, S_TX_STAT_W);
        end
        first = (txlog_a.size() > 0) ? txlog_a[0] : '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_en !== 1'b0 || a_tx !== 16'd0 || a_rx !== 16'd0 || a_done !== 1'b0 || dut_a.state_q !== S_IDLE) begin
            errors++; $display("FAIL mid_reset got en=%b tx=%0d state=%0d want 0 0 %0d", a_en, a_tx, dut_a.state_q, S_IDLE);
        end
        @(negedge clk);
        txlog_a.delete();
        reset = 1'b0;
        cyc = 0;
        while (txlog_a.size() < 1 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (txlog_a.size() < 1 || txlog_a[0] !== first || first !== exp_pkt(0, 0, 2, 3, 0)) begin
            errors++; $display("FAIL mid_rerun got n=%0d first=%h want %h", txlog_a.size(), (txlog_a.size() > 0) ? txlog_a[0] : '0, exp_pkt(0, 0, 2, 3, 0));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fixed_done();
        test_full();
        test_rx_check();
        test_rx_random();
        test_sweep();
        test_random();
        test_skip();
        test_reset_mid();
        checks++;
        if (proto_errs != 0) begin
            errors++; $display("FAIL strobe_protocol got %0d violations want 0", proto_errs);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1);
    end

endmodule
